fetch_stage: RTL and testbench

F-stage PC register plus F/D pipeline register for the 5-stage MIPS core. It sits directly upstream of the hazard unit. It produces instr_d, which the hazard unit decodes, and it consumes that unit's stall output to freeze fetch. It also handles branch/jump redirect, eret return, exception vectoring and fetch address errors (AdEL), and tags branch-delay-slot instructions for CP0.

---
 rtl/fetch_stage_pkg.sv | 48 ++++
 rtl/fetch_stage_pipe_reg_fd.sv | 48 ++++
 rtl/fetch_stage.sv | 103 ++++++++++
 tb/tb_fetch_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage and CP0: reset and vector
// addresses, the instruction memory window and the ExcCode values.
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES = 32'h0000_4000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  // ExcCode values as written into CP0 Cause
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Next-PC source, listed from highest to lowest priority
  typedef enum logic [2:0] {
    NPC_EXC,
    NPC_ERET,
    NPC_HOLD,
    NPC_BRANCH,
    NPC_SEQ
  } npc_sel_e;

  // Contents of the F/D pipeline register (pc8 is derived alongside)
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc_code;
    logic        valid;
  } fd_t;

  // True when a fetch address is misaligned or outside [base, base+bytes).
  // The upper bound is formed in 33 bits so a window touching 2^32 cannot wrap.
  function automatic logic fetch_addr_bad(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] bytes);
    logic [32:0] limit;
    limit = {1'b0, base} + {1'b0, bytes};
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/fetch_stage_pipe_reg_fd.sv
// F/D pipeline register: async reset, load enable and a synchronous flush
// that turns the slot into a bubble tagged with the redirect address.
module pipe_reg_fd
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  fd_t         d,
  output fd_t         q,
  output logic [31:0] pc8_q
);

  fd_t         q_reg;
  logic [31:0] pc8_reg;

  // Register update: reset to a bubble, flush to a bubble, or load the fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg.instr    <= NOP;
      q_reg.pc       <= RESET_PC;
      q_reg.bd       <= 1'b0;
      q_reg.exc_code <= EXC_NONE;
      q_reg.valid    <= 1'b0;
      pc8_reg        <= RESET_PC + 32'd8;
    end else if (en) begin
      if (flush) begin
        q_reg.instr    <= NOP;
        q_reg.pc       <= flush_pc;
        q_reg.bd       <= 1'b0;
        q_reg.exc_code <= EXC_NONE;
        q_reg.valid    <= 1'b0;
        pc8_reg        <= flush_pc + 32'd8;
      end else begin
        q_reg   <= d;
        pc8_reg <= d.pc + 32'd8;
      end
    end
  end

  assign q     = q_reg;
  assign pc8_q = pc8_reg;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC priority mux (exception, eret, stall,
// branch, sequential) and fetch address check feeding the F/D register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET_P = PC_RESET,
  parameter logic [31:0] EXC_VEC_P  = EXC_VEC,
  parameter logic [31:0] IM_BASE_P  = IM_BASE,
  parameter logic [31:0] IM_BYTES_P = IM_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_f,
  input  logic [31:0] instr_im,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        is_branch_d,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        exc_req,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        bd_d,
  output logic [4:0]  exc_code_d,
  output logic        valid_d
);

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  npc_sel_e    npc_sel;
  logic        fetch_bad;
  logic        fd_en;
  logic        fd_flush;
  fd_t         fd_d;
  fd_t         fd_q;

  // Choose the next-PC source; exception beats eret beats stall beats branch
  always_comb begin
    npc_sel = NPC_SEQ;
    if (exc_req)           npc_sel = NPC_EXC;
    else if (eret)         npc_sel = NPC_ERET;
    else if (stall)        npc_sel = NPC_HOLD;
    else if (branch_taken) npc_sel = NPC_BRANCH;
  end

  // Next-PC value for the selected source; sequential fetch wraps mod 2^32
  always_comb begin
    pc_next = pc_reg + 32'd4;
    case (npc_sel)
      NPC_EXC:    pc_next = EXC_VEC_P;
      NPC_ERET:   pc_next = epc;
      NPC_HOLD:   pc_next = pc_reg;
      NPC_BRANCH: pc_next = branch_target;
      default:    pc_next = pc_reg + 32'd4;
    endcase
  end

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_reg <= PC_RESET_P;
    else       pc_reg <= pc_next;
  end

  assign pc_f = pc_reg;

  // What the F/D register would capture this edge. A bad fetch address is
  // delivered as a valid AdEL slot carrying the faulting PC for CP0; the
  // delay-slot tag comes from the branch in D, taken or not.
  always_comb begin
    fetch_bad     = fetch_addr_bad(pc_reg, IM_BASE_P, IM_BYTES_P);
    fd_d.instr    = fetch_bad ? NOP : instr_im;
    fd_d.pc       = pc_reg;
    fd_d.bd       = branch_taken | is_branch_d;
    fd_d.exc_code = fetch_bad ? EXC_ADEL : EXC_NONE;
    fd_d.valid    = 1'b1;
  end

  // Exception and eret redirects must squash the slot even during a stall
  assign fd_flush = exc_req | eret;
  assign fd_en    = ~stall | fd_flush;

  pipe_reg_fd #(
    .RESET_PC (PC_RESET_P)
  ) u_pipe_reg_fd (
    .clk      (clk),
    .reset    (reset),
    .en       (fd_en),
    .flush    (fd_flush),
    .flush_pc (pc_next),
    .d        (fd_d),
    .q        (fd_q),
    .pc8_q    (pc8_d)
  );

  assign instr_d    = fd_q.instr;
  assign pc_d       = fd_q.pc;
  assign bd_d       = fd_q.bd;
  assign exc_code_d = fd_q.exc_code;
  assign valid_d    = fd_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns {16'hC0DE, pc[15:0]}
// so each fetched word identifies its own address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_f;
  logic [31:0] instr_im;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        is_branch_d;
  logic        eret;
  logic [31:0] epc;
  logic        exc_req;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        bd_d;
  logic [4:0]  exc_code_d;
  logic        valid_d;

  int checks = 0;
  int errors = 0;

  // Observed snapshot: pc_f, instr_d, pc_d, pc8_d, bd_d, exc_code_d, valid_d
  logic [134:0] obs;
  logic [134:0] exp_v;
  assign obs = {pc_f, instr_d, pc_d, pc8_d, bd_d, exc_code_d, valid_d};

  assign instr_im = {16'hC0DE, pc_f[15:0]};

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .pc_f          (pc_f),
    .instr_im      (instr_im),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .is_branch_d   (is_branch_d),
    .eret          (eret),
    .epc           (epc),
    .exc_req       (exc_req),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .pc8_d         (pc8_d),
    .bd_d          (bd_d),
    .exc_code_d    (exc_code_d),
    .valid_d       (valid_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t pc_f=%h instr_d=%h pc_d=%h pc8_d=%h bd=%b exc=%0d valid=%b",
             $time, pc_f, instr_d, pc_d, pc8_d, bd_d, exc_code_d, valid_d);
  endtask

  task automatic clear_ctrl();
    stall = 0; branch_taken = 0; branch_target = 0; is_branch_d = 0;
    eret = 0; epc = 0; exc_req = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_ctrl();
    tick(); tick();
    exp_v = {32'h3000, 32'h0, 32'h3000, 32'h3008, 1'b0, 5'd0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs, exp_v); end
    reset = 0;
  endtask

  task automatic test_sequential();
    tick();
    exp_v = {32'h3004, 32'hC0DE3000, 32'h3000, 32'h3008, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL seq_0 got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {32'h3008, 32'hC0DE3004, 32'h3004, 32'h300C, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL seq_1 got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_stall();
    stall = 1;
    tick();
    exp_v = {32'h3008, 32'hC0DE3004, 32'h3004, 32'h300C, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_0 got=%h exp=%h", obs, exp_v); end
    branch_taken = 1; branch_target = 32'h3100;   // ignored while stalled
    tick();
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_1_branch_ignored got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
    tick();
    exp_v = {32'h300C, 32'hC0DE3008, 32'h3008, 32'h3010, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_release got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {32'h3010, 32'hC0DE300C, 32'h300C, 32'h3014, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL stall_after got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_branch();
    is_branch_d = 1; branch_taken = 1; branch_target = 32'h3100;
    tick();
    exp_v = {32'h3100, 32'hC0DE3010, 32'h3010, 32'h3018, 1'b1, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL branch_slot got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
    tick();
    exp_v = {32'h3104, 32'hC0DE3100, 32'h3100, 32'h3108, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL branch_target got=%h exp=%h", obs, exp_v); end
    is_branch_d = 1;   // not-taken branch still owns a delay slot
    tick();
    exp_v = {32'h3108, 32'hC0DE3104, 32'h3104, 32'h310C, 1'b1, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL branch_nt_slot got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
  endtask

  task automatic test_exc_over_stall();
    stall = 1; exc_req = 1;
    tick();
    exp_v = {32'h4180, 32'h0, 32'h4180, 32'h4188, 1'b0, 5'd0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL exc_stall got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
    tick();
    exp_v = {32'h4184, 32'hC0DE4180, 32'h4180, 32'h4188, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL exc_handler got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_eret_bad_epc();
    eret = 1; epc = 32'h3002;
    tick();
    exp_v = {32'h3002, 32'h0, 32'h3002, 32'h300A, 1'b0, 5'd0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL eret_redirect got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
    tick();
    exp_v = {32'h3006, 32'h0, 32'h3002, 32'h300A, 1'b0, 5'd4, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL eret_adel got=%h exp=%h", obs, exp_v); end
    exc_req = 1; eret = 1; epc = 32'h3200;
    tick();
    exp_v = {32'h4180, 32'h0, 32'h4180, 32'h4188, 1'b0, 5'd0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL exc_beats_eret got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
    tick();
    exp_v = {32'h4184, 32'hC0DE4180, 32'h4180, 32'h4188, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL exc_beats_eret_next got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_range_bounds();
    branch_taken = 1; branch_target = 32'h6FFC;
    tick();
    exp_v = {32'h6FFC, 32'hC0DE4184, 32'h4184, 32'h418C, 1'b1, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL range_jump got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
    tick();
    exp_v = {32'h7000, 32'hC0DE6FFC, 32'h6FFC, 32'h7004, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL range_last_ok got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {32'h7004, 32'h0, 32'h7000, 32'h7008, 1'b0, 5'd4, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL range_top_adel got=%h exp=%h", obs, exp_v); end
    branch_taken = 1; branch_target = 32'h2FFC;
    tick();
    exp_v = {32'h2FFC, 32'h0, 32'h7004, 32'h700C, 1'b1, 5'd4, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL range_bad_slot got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
    tick();
    exp_v = {32'h3000, 32'h0, 32'h2FFC, 32'h3004, 1'b0, 5'd4, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL range_low_adel got=%h exp=%h", obs, exp_v); end
    tick();
    exp_v = {32'h3004, 32'hC0DE3000, 32'h3000, 32'h3008, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL range_base_ok got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_wrap();
    branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    tick();
    exp_v = {32'hFFFF_FFFC, 32'hC0DE3004, 32'h3004, 32'h300C, 1'b1, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL wrap_jump got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
    tick();
    exp_v = {32'h0, 32'h0, 32'hFFFF_FFFC, 32'h4, 1'b0, 5'd4, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", obs, exp_v); end
  endtask

  task automatic test_async_reset();
    branch_taken = 1; branch_target = 32'h3020;
    tick();
    exp_v = {32'h3020, 32'h0, 32'h0, 32'h8, 1'b1, 5'd4, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL pre_reset got=%h exp=%h", obs, exp_v); end
    branch_taken = 1; branch_target = 32'h3100;   // pending redirect must not survive
    #2;
    reset = 1;
    #1;                                           // mid-cycle, no clock edge yet
    exp_v = {32'h3000, 32'h0, 32'h3000, 32'h3008, 1'b0, 5'd0, 1'b0};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL async_reset got=%h exp=%h", obs, exp_v); end
    tick();
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset_over_branch got=%h exp=%h", obs, exp_v); end
    clear_ctrl();
    #2;
    reset = 0;
    tick();
    exp_v = {32'h3004, 32'hC0DE3000, 32'h3000, 32'h3008, 1'b0, 5'd0, 1'b1};
    checks++; if (obs !== exp_v) begin errors++; $display("FAIL post_reset got=%h exp=%h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_exc_over_stall();
    test_eret_bad_epc();
    test_range_bounds();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
